// File: rtl/bus_pkg.sv
// Shared types and decode constants for the system data bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_SLAVES = 8;

    // Address decode: bit 31 flags an unmapped region, bits 30:28 select the slave.
    localparam int SEL_MSB = 30;
    localparam int SEL_LSB = 28;
    localparam int ERR_BIT = 31;

    localparam logic [2:0] SLV_UROM = 3'd0;
    localparam logic [2:0] SLV_SRAM = 3'd1;
    localparam logic [2:0] SLV_UART = 3'd2;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

endpackage

// File: rtl/bus_rr_picker.sv
// Two-way round-robin selector: on a tie the master that did not win last time is chosen.
module bus_rr_picker (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            sel = ~last_grant;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / eight-slave bus arbiter: picks a master, runs one slave access with a
// timeout, and returns read data or an error as a single-cycle completion pulse.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NUM_SLAVES     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      m0_req_i,
    input  logic [31:0]               m0_addr_i,
    input  logic [31:0]               m0_wdata_i,
    input  logic                      m0_we_i,
    input  logic                      m0_re_i,
    input  logic [1:0]                m0_hb_i,
    output logic                      m0_gnt_o,
    output logic [31:0]               m0_rdata_o,
    output logic                      m0_err_o,

    input  logic                      m1_req_i,
    input  logic [31:0]               m1_addr_i,
    input  logic [31:0]               m1_wdata_i,
    input  logic                      m1_we_i,
    input  logic                      m1_re_i,
    input  logic [1:0]                m1_hb_i,
    output logic                      m1_gnt_o,
    output logic [31:0]               m1_rdata_o,
    output logic                      m1_err_o,

    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    output logic                      s_we_o,
    output logic                      s_re_o,
    output logic [1:0]                s_hb_o,
    output logic                      s_req_o,
    output logic [NUM_SLAVES-1:0]     s_ce_o,
    input  logic                      s_gnt_i,
    input  logic [32*NUM_SLAVES-1:0]  s_rdata_i,

    output logic                      busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;

    logic              pick_valid;
    logic              pick_sel;
    logic              last_grant;

    logic [31:0]       pick_addr;
    logic [31:0]       pick_wdata;
    logic              pick_we;
    logic              pick_re;
    logic [1:0]        pick_hb;

    logic              master_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              re_q;
    logic [1:0]        hb_q;
    logic [2:0]        slv_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic              timeout;

    function automatic logic [31:0] slave_word(input logic [32*NUM_SLAVES-1:0] bus,
                                               input logic [2:0] idx);
        return bus[{idx, 5'b0} +: 32];
    endfunction

    bus_rr_picker u_picker (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .sel        (pick_sel)
    );

    always_comb begin
        pick_addr  = pick_sel ? m1_addr_i  : m0_addr_i;
        pick_wdata = pick_sel ? m1_wdata_i : m0_wdata_i;
        pick_we    = pick_sel ? m1_we_i    : m0_we_i;
        pick_re    = pick_sel ? m1_re_i    : m0_re_i;
        pick_hb    = pick_sel ? m1_hb_i    : m0_hb_i;
    end

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A slave grant arriving on the last timeout cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = pick_addr[ERR_BIT] ? RESP : XFER;
                end
            end
            XFER: begin
                if (s_gnt_i || timeout) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            master_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            hb_q       <= '0;
            slv_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        master_q <= pick_sel;
                        addr_q   <= pick_addr;
                        wdata_q  <= pick_wdata;
                        we_q     <= pick_we;
                        re_q     <= pick_re;
                        hb_q     <= pick_hb;
                        slv_q    <= pick_addr[SEL_MSB:SEL_LSB];
                        cnt      <= '0;
                        rdata_q  <= '0;
                        err_q    <= pick_addr[ERR_BIT];
                    end
                end
                XFER: begin
                    if (s_gnt_i) begin
                        rdata_q <= re_q ? slave_word(s_rdata_i, slv_q) : 32'h0;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= master_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_req_o    = 1'b0;
        s_ce_o     = '0;
        s_we_o     = 1'b0;
        s_re_o     = 1'b0;
        m0_gnt_o   = 1'b0;
        m0_rdata_o = '0;
        m0_err_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        m1_rdata_o = '0;
        m1_err_o   = 1'b0;
        busy_o     = (state != IDLE);
        case (state)
            XFER: begin
                s_req_o = 1'b1;
                s_ce_o  = NUM_SLAVES'(1) << slv_q;
                s_we_o  = we_q;
                s_re_o  = re_q;
            end
            RESP: begin
                if (master_q) begin
                    m1_gnt_o   = 1'b1;
                    m1_rdata_o = rdata_q;
                    m1_err_o   = err_q;
                end else begin
                    m0_gnt_o   = 1'b1;
                    m0_rdata_o = rdata_q;
                    m0_err_o   = err_q;
                end
            end
            default: ;
        endcase
    end

    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
    assign s_hb_o    = hb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transfers
// compared against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         m0_req_i, m1_req_i;
    logic [31:0]  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic         m0_we_i, m1_we_i, m0_re_i, m1_re_i;
    logic [1:0]   m0_hb_i, m1_hb_i;
    logic         m0_gnt_o, m1_gnt_o, m0_err_o, m1_err_o;
    logic [31:0]  m0_rdata_o, m1_rdata_o;
    logic [31:0]  s_addr_o, s_wdata_o;
    logic         s_we_o, s_re_o, s_req_o, s_gnt_i, busy_o;
    logic [1:0]   s_hb_o;
    logic [7:0]   s_ce_o;
    logic [255:0] s_rdata_i;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .NUM_SLAVES(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_we_i(m0_we_i), .m0_re_i(m0_re_i), .m0_hb_i(m0_hb_i),
        .m0_gnt_o(m0_gnt_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_we_i(m1_we_i), .m1_re_i(m1_re_i), .m1_hb_i(m1_hb_i),
        .m1_gnt_o(m1_gnt_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_we_o(s_we_o), .s_re_o(s_re_o),
        .s_hb_o(s_hb_o), .s_req_o(s_req_o), .s_ce_o(s_ce_o), .s_gnt_i(s_gnt_i),
        .s_rdata_i(s_rdata_i), .busy_o(busy_o)
    );

    int total = 0;
    int passed = 0;
    int model_last;

    int          obs_lat, obs_gm, obs_xfer;
    logic [31:0] obs_rd, obs_saddr, obs_swdata;
    logic        obs_er, obs_other_bad, obs_leak, obs_swe, obs_sre;
    logic [1:0]  obs_shb;
    logic [7:0]  obs_ce;

    function automatic logic [31:0] word_of(input logic [255:0] b, input int k);
        return b[32*k +: 32];
    endfunction

    // Reference timing: decode error 1 cycle, slave answering after w wait cycles
    // 2+w, otherwise the timeout fires after TO cycles in the slave phase.
    function automatic int exp_latency(input logic [31:0] a, input int w);
        if (a[31]) return 1;
        if (w < TO) return 2 + w;
        return 1 + TO;
    endfunction

    task automatic drive_m(input int idx, input logic req, input logic [31:0] a,
                           input logic [31:0] wd, input logic we, input logic re,
                           input logic [1:0] hb);
        if (idx == 0) begin
            m0_req_i = req; m0_addr_i = a; m0_wdata_i = wd;
            m0_we_i = we; m0_re_i = re; m0_hb_i = hb;
        end else begin
            m1_req_i = req; m1_addr_i = a; m1_wdata_i = wd;
            m1_we_i = we; m1_re_i = re; m1_hb_i = hb;
        end
    endtask

    task automatic rand_bus();
        for (int k = 0; k < 8; k++) s_rdata_i[32*k +: 32] = $urandom;
    endtask

    // Clocks until a completion pulse; the slave model asserts s_gnt_i on slave-phase
    // cycle wait_n+1. Only records observations.
    task automatic run_txn(input int wait_n);
        bit done;
        done = 0;
        obs_lat = -1; obs_gm = -1; obs_xfer = 0; obs_rd = '0; obs_er = 1'b0;
        obs_ce = '0; obs_other_bad = 1'b0; obs_leak = 1'b0;
        obs_saddr = '0; obs_swdata = '0; obs_swe = 1'b0; obs_sre = 1'b0; obs_shb = '0;
        for (int n = 1; n <= 60 && !done; n++) begin
            @(posedge clk); #1;
            if (s_req_o) begin
                obs_xfer++;
                if (obs_xfer == 1) begin
                    obs_saddr = s_addr_o; obs_swdata = s_wdata_o;
                    obs_swe = s_we_o; obs_sre = s_re_o; obs_shb = s_hb_o;
                end
            end
            obs_ce |= s_ce_o;
            if (!m0_gnt_o && (m0_rdata_o != 0 || m0_err_o)) obs_leak = 1'b1;
            if (!m1_gnt_o && (m1_rdata_o != 0 || m1_err_o)) obs_leak = 1'b1;
            if (m0_gnt_o || m1_gnt_o) begin
                obs_lat = n;
                obs_gm  = m1_gnt_o ? 1 : 0;
                obs_rd  = m1_gnt_o ? m1_rdata_o : m0_rdata_o;
                obs_er  = m1_gnt_o ? m1_err_o : m0_err_o;
                obs_other_bad = m1_gnt_o ? m0_gnt_o : m1_gnt_o;
                done = 1;
            end
            s_gnt_i = s_req_o && (obs_xfer == wait_n + 1);
        end
        s_gnt_i = 1'b0;
    endtask

    task automatic idle_gap();
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_m(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        drive_m(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        s_gnt_i = 1'b0; s_rdata_i = '0;
        repeat (2) @(posedge clk); #1;
        total++;
        if ({busy_o, s_req_o, s_ce_o, m0_gnt_o, m1_gnt_o, m0_err_o, m1_err_o, s_we_o, s_re_o} !== '0)
            $display("FAIL reset_ctrl: got busy=%b req=%b ce=%h g0=%b g1=%b want all 0",
                     busy_o, s_req_o, s_ce_o, m0_gnt_o, m1_gnt_o);
        else passed++;
        total++;
        if ({m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o, s_hb_o} !== '0)
            $display("FAIL reset_data: got r0=%h r1=%h addr=%h wdata=%h want 0",
                     m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o);
        else passed++;
        drive_m(0, 1'b1, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 2'b10);
        @(posedge clk); #1;
        total++;
        if (busy_o !== 1'b0) $display("FAIL reset_hold: busy=%b want 0", busy_o);
        else passed++;
        m0_req_i = 1'b0;
        @(negedge clk) rst_i = 1'b0;
        model_last = 1;
    endtask

    task automatic test_single_read();
        rand_bus();
        s_rdata_i[63:32] = 32'hDEAD_BEEF;
        drive_m(0, 1'b1, 32'h1000_0004, 32'h0, 1'b0, 1'b1, 2'b10);
        run_txn(0);
        total++;
        if (obs_gm !== 0 || obs_lat !== 2)
            $display("FAIL single_grant: master=%0d lat=%0d want master=0 lat=2", obs_gm, obs_lat);
        else passed++;
        total++;
        if (obs_rd !== 32'hDEAD_BEEF || obs_er !== 1'b0)
            $display("FAIL single_data: rdata=%h err=%b want deadbeef err=0", obs_rd, obs_er);
        else passed++;
        total++;
        if (obs_ce !== 8'h02 || obs_xfer !== 1 || obs_saddr !== 32'h1000_0004 || obs_sre !== 1'b1)
            $display("FAIL single_slave: ce=%h xfer=%0d addr=%h re=%b want 02 1 10000004 1",
                     obs_ce, obs_xfer, obs_saddr, obs_sre);
        else passed++;
        model_last = 0;
        idle_gap();
    endtask

    task automatic test_decode_error();
        drive_m(0, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 2'b10);
        run_txn(0);
        total++;
        if (obs_gm !== 0 || obs_lat !== 1 || obs_er !== 1'b1 || obs_rd !== 32'h0)
            $display("FAIL decode_err: master=%0d lat=%0d err=%b rdata=%h want 0 1 1 0",
                     obs_gm, obs_lat, obs_er, obs_rd);
        else passed++;
        total++;
        if (obs_xfer !== 0 || obs_ce !== 8'h00)
            $display("FAIL decode_noslave: xfer=%0d ce=%h want 0 00", obs_xfer, obs_ce);
        else passed++;
        model_last = 0;
        idle_gap();
    endtask

    task automatic test_timeout();
        rand_bus();
        drive_m(1, 1'b1, 32'h3000_0000, 32'hCAFE_0001, 1'b1, 1'b0, 2'b10);
        run_txn(1000);
        total++;
        if (obs_gm !== 1 || obs_lat !== TO + 1)
            $display("FAIL timeout_grant: master=%0d lat=%0d want 1 %0d", obs_gm, obs_lat, TO + 1);
        else passed++;
        total++;
        if (obs_er !== 1'b1 || obs_rd !== 32'h0 || obs_ce !== 8'h08 || obs_xfer !== TO)
            $display("FAIL timeout_resp: err=%b rdata=%h ce=%h xfer=%0d want 1 0 08 %0d",
                     obs_er, obs_rd, obs_ce, obs_xfer, TO);
        else passed++;
        total++;
        if (obs_swe !== 1'b1 || obs_sre !== 1'b0 || obs_swdata !== 32'hCAFE_0001)
            $display("FAIL timeout_write: we=%b re=%b wdata=%h want 1 0 cafe0001",
                     obs_swe, obs_sre, obs_swdata);
        else passed++;
        model_last = 1;
        idle_gap();
    endtask

    task automatic test_coincidence();
        rand_bus();
        drive_m(0, 1'b1, 32'h2000_0010, 32'h0, 1'b0, 1'b1, 2'b01);
        run_txn(TO - 1);
        total++;
        if (obs_lat !== TO + 1 || obs_er !== 1'b0 || obs_rd !== word_of(s_rdata_i, 2))
            $display("FAIL coincide: lat=%0d err=%b rdata=%h want %0d 0 %h",
                     obs_lat, obs_er, obs_rd, TO + 1, word_of(s_rdata_i, 2));
        else passed++;
        model_last = 0;
        idle_gap();
    endtask

    task automatic test_contention();
        int exp_m;
        drive_m(0, 1'b1, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 2'b10);
        drive_m(1, 1'b1, 32'h2000_0004, 32'h0, 1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 6; i++) begin
            rand_bus();
            exp_m = 1 - model_last;
            run_txn(0);
            total++;
            if (obs_gm !== exp_m || obs_lat !== (i == 0 ? 2 : 3) ||
                obs_rd !== word_of(s_rdata_i, exp_m + 1) || obs_other_bad !== 1'b0)
                $display("FAIL contention_%0d: master=%0d lat=%0d rdata=%h want %0d %0d %h",
                         i, obs_gm, obs_lat, obs_rd, exp_m, (i == 0 ? 2 : 3),
                         word_of(s_rdata_i, exp_m + 1));
            else passed++;
            model_last = exp_m;
        end
        idle_gap();
    endtask

    task automatic test_random();
        logic [31:0] ra [2];
        logic [31:0] rw [2];
        logic        rwe [2];
        logic        rre [2];
        logic [1:0]  rhb [2];
        int waits [7] = '{0, 1, 2, 3, 15, 16, 20};
        int mode, win, w, exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_ce;
        for (int it = 0; it < 30; it++) begin
            rand_bus();
            for (int m = 0; m < 2; m++) begin
                ra[m] = $urandom;
                ra[m][31] = ($urandom_range(0, 5) == 0);
                rw[m] = $urandom;
                rwe[m] = $urandom_range(0, 1);
                rre[m] = $urandom_range(0, 1);
                rhb[m] = 2'($urandom_range(0, 2));
            end
            mode = $urandom_range(0, 2);
            w = waits[$urandom_range(0, 6)];
            win = (mode == 2) ? 1 - model_last : mode;
            for (int m = 0; m < 2; m++)
                drive_m(m, (mode == 2) || (mode == m), ra[m], rw[m], rwe[m], rre[m], rhb[m]);
            exp_lat = exp_latency(ra[win], w);
            exp_err = ra[win][31] || (w >= TO);
            exp_rd  = exp_err ? 32'h0 : (rre[win] ? word_of(s_rdata_i, int'(ra[win][30:28])) : 32'h0);
            exp_ce  = ra[win][31] ? 8'h00 : (8'h01 << ra[win][30:28]);
            run_txn(w);
            total++;
            if (obs_gm !== win || obs_lat !== exp_lat)
                $display("FAIL rand_%0d_grant: master=%0d lat=%0d want %0d %0d",
                         it, obs_gm, obs_lat, win, exp_lat);
            else passed++;
            total++;
            if (obs_er !== exp_err || obs_rd !== exp_rd)
                $display("FAIL rand_%0d_resp: err=%b rdata=%h want %b %h",
                         it, obs_er, obs_rd, exp_err, exp_rd);
            else passed++;
            total++;
            if (obs_ce !== exp_ce || obs_other_bad !== 1'b0 || obs_leak !== 1'b0)
                $display("FAIL rand_%0d_side: ce=%h other=%b leak=%b want %h 0 0",
                         it, obs_ce, obs_other_bad, obs_leak, exp_ce);
            else passed++;
            if (!ra[win][31]) begin
                total++;
                if ({obs_saddr, obs_swdata, obs_swe, obs_sre, obs_shb} !==
                    {ra[win], rw[win], rwe[win], rre[win], rhb[win]})
                    $display("FAIL rand_%0d_latch: addr=%h wdata=%h we=%b re=%b hb=%b want %h %h %b %b %b",
                             it, obs_saddr, obs_swdata, obs_swe, obs_sre, obs_shb,
                             ra[win], rw[win], rwe[win], rre[win], rhb[win]);
                else passed++;
            end
            model_last = win;
            idle_gap();
            total++;
            if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 || busy_o !== 1'b0)
                $display("FAIL rand_%0d_pulse: g0=%b g1=%b busy=%b want 0 0 0",
                         it, m0_gnt_o, m1_gnt_o, busy_o);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        bad = 1'b0;
        drive_m(1, 1'b1, 32'h3000_0000, 32'h1234_5678, 1'b1, 1'b0, 2'b10);
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (s_req_o !== 1'b1 || s_ce_o !== 8'h08)
            $display("FAIL rstmid_pre: req=%b ce=%h want 1 08", s_req_o, s_ce_o);
        else passed++;
        #2 rst_i = 1'b1;
        #1;
        total++;
        if ({s_req_o, s_ce_o, busy_o} !== '0)
            $display("FAIL rstmid_async: req=%b ce=%h busy=%b want 0 00 0", s_req_o, s_ce_o, busy_o);
        else passed++;
        drive_m(0, 1'b1, 32'h1000_0000, 32'h0, 1'b0, 1'b1, 2'b10);
        drive_m(1, 1'b1, 32'h2000_0000, 32'h0, 1'b0, 1'b1, 2'b10);
        rand_bus();
        repeat (2) begin
            @(posedge clk); #1;
            if (m0_gnt_o || m1_gnt_o || busy_o) bad = 1'b1;
        end
        total++;
        if (bad !== 1'b0) $display("FAIL rstmid_nognt: activity=%b want 0", bad);
        else passed++;
        @(negedge clk) rst_i = 1'b0;
        model_last = 1;
        run_txn(0);
        total++;
        if (obs_gm !== 0 || obs_lat !== 2 || obs_rd !== word_of(s_rdata_i, 1))
            $display("FAIL rstmid_first: master=%0d lat=%0d rdata=%h want 0 2 %h",
                     obs_gm, obs_lat, obs_rd, word_of(s_rdata_i, 1));
        else passed++;
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_decode_error();
        test_timeout();
        test_coincidence();
        test_contention();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, eight-slave arbiter and sequencer for the system data bus.
- Grants the bus round-robin between master 0 (core) and master 1 (e.g. a DMA engine).
- Latches the winning request, drives a one-hot chip enable from the address, waits for the slave grant, and returns read data or an error to the winner.
- A timeout counter keeps an unresponsive slave from hanging the bus.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in XFER waiting for s_gnt_i before the error response (min 2).
NUM_SLAVES, 8, number of chip enables; fixed to match the 3-bit decode field.

Ports:
- Clock and reset:
  - clk_i  input  1  single clock, all logic rising-edge.
  - rst_i  input  1  asynchronous, active-high reset.
- Master ports (N = 0, 1):
  - mN_req_i  input  1  request; held high with stable signals until mN_gnt_o.
  - mN_addr_i  input  32  byte address.
  - mN_wdata_i  input  32  write data.
  - mN_we_i  input  1  write enable.
  - mN_re_i  input  1  read enable.
  - mN_hb_i  input  2  access size (00 byte, 01 half, 10 word).
  - mN_gnt_o  output  1  one-cycle completion pulse.
  - mN_rdata_o  output  32  read data, valid while mN_gnt_o is high.
  - mN_err_o  output  1  error flag, valid while mN_gnt_o is high.
- Slave side:
  - s_addr_o  output  32  latched address.
  - s_wdata_o  output  32  latched write data.
  - s_we_o  output  1  latched write enable, gated by XFER.
  - s_re_o  output  1  latched read enable, gated by XFER.
  - s_hb_o  output  2  latched size.
  - s_req_o  output  1  high only in XFER.
  - s_ce_o  output  8  one-hot chip enable, nonzero only in XFER.
  - s_gnt_i  input  1  OR of all slave grants.
  - s_rdata_i  input  256  slave k read data at bits [32k+31:32k].
- Status:
  - busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, any state including mid-transfer):
  - state=IDLE.
  - All outputs 0.
  - Latched registers cleared.
  - last_grant=1, so master 0 wins the first tie.
  - The timeout counter is cleared.
- States: IDLE, XFER, RESP.
- IDLE:
  - No request: stay.
  - One requester: select it.
  - Both requesting: select the master that is not last_grant.
  - On selection, latch addr/wdata/we/re/hb and the master index, and compute slave index = addr[30:28].
  - If addr[31]=1: set err_pending, go to RESP (decode error, no slave access).
  - Otherwise: go to XFER, counter=0.
- XFER:
  - s_req_o=1.
  - s_ce_o = 1 << slave index.
  - s_we_o/s_re_o driven from the latched values.
  - If s_gnt_i=1 in this cycle: register s_rdata_i slice[slave index] if re was set (0 for writes), err=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: err=1, rdata=0, go to RESP.
  - Else: counter+1.
  - If s_gnt_i and timeout coincide, the grant wins.
- RESP:
  - The selected master's gnt_o=1 for exactly one cycle, with its rdata_o/err_o.
  - The other master's outputs stay 0.
  - last_grant is updated to the selected master.
  - Next state is IDLE unconditionally; no back-to-back grant without passing through IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle t, zero-wait slave → mN_gnt_o at t+2.
  - Decode error → mN_gnt_o at t+1.
  - Timeout → mN_gnt_o at t+1+TIMEOUT_CYCLES.
  - Maximum throughput: one transfer per 3 cycles.
- Misuse and corner cases:
  - Master inputs are ignored after latching; deasserting req mid-transfer is a protocol violation, and the transfer still completes and pulses gnt.
  - s_gnt_i in IDLE or RESP is ignored.
  - A request with both we and re low is passed through; the slave grant still completes it.
  - mN_rdata_o and mN_err_o are 0 whenever mN_gnt_o is 0.
- Widths: counter width = clog2(TIMEOUT_CYCLES); no arithmetic on data paths.

Decomposition:
- Package bus_pkg:
  - state enum {IDLE, XFER, RESP}.
  - NUM_SLAVES=8.
  - Decode field constants: SEL_MSB=30, SEL_LSB=28, ERR_BIT=31.
  - Slave indices SLV_UROM=0, SLV_SRAM=1, SLV_UART=2.
  - hb encodings.
- One sub-module: bus_rr_picker.
  - Purely combinational 2-way round-robin selector.
  - Inputs: req[1:0], last_grant. Outputs: valid, sel.
- The FSM, latches, counter and rdata mux stay in bus_arbiter.

Test Plan:
1. Single read: m0 read addr 0x1000_0004, slave 1 returns s_gnt_i in the first XFER cycle with rdata 0xDEADBEEF → s_ce_o=0x02 for one cycle; m0_gnt_o pulses at t+2 with m0_rdata_o=0xDEADBEEF, m0_err_o=0.
2. Contention: m0 and m1 both request reads, zero-wait slaves, held continuously → grants alternate m0, m1, m0, m1, one every 3 cycles; never two grants to the same master while the other is waiting.
3. Timeout: m1 writes addr 0x3000_0000, s_gnt_i held low, TIMEOUT_CYCLES=16 → s_ce_o=0x08 for 16 cycles, then m1_gnt_o=1 with m1_err_o=1 and m1_rdata_o=0 at t+17.
4. Decode error: m0 reads 0x8000_0000 → s_req_o and s_ce_o stay 0 throughout; m0_gnt_o with m0_err_o=1 at t+1.
5. Grant/timeout coincidence: s_gnt_i first asserted on XFER cycle 16 → err=0 and rdata captured.
6. Reset mid-transfer: assert rst_i during XFER → s_req_o, s_ce_o, busy_o drop to 0 immediately (asynchronously); no gnt pulse; after release, simultaneous requests grant m0 first.
